// File: rtl/sys_in_port.sv
// Input-port FIFO: an external producer pushes words at the full clock rate, and the CPU
// pops them on slow-clock strobes through a combinational bus word.
module sys_in_port #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     SLOW_CLOCK_STRB,
    input  logic [WIDTH-1:0]         SYS_IN_DATA,
    input  logic                     SYS_IN_VALID,
    output logic                     SYS_IN_READY,
    input  logic                     IN_OUT,
    output logic [WIDTH-1:0]         DATA_OUT,
    output logic                     EMPTY,
    output logic                     FULL,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     UNDERFLOW
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             underflow_q, underflow_d;

    logic push, pop_req, pop;

    assign EMPTY        = (count_q == '0);
    assign FULL         = (count_q == FULL_COUNT);
    assign SYS_IN_READY = ~FULL;
    assign COUNT        = count_q;
    assign UNDERFLOW    = underflow_q;

    assign push    = SYS_IN_VALID & ~FULL;
    assign pop_req = SLOW_CLOCK_STRB & IN_OUT;
    assign pop     = pop_req & ~EMPTY;

    // The bus word must settle before the consumer latches it on the same strobe edge.
    assign DATA_OUT = (IN_OUT && !EMPTY) ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        underflow_d = underflow_q;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (pop_req && EMPTY) underflow_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (RST) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; an empty FIFO never exposes it.
    always_ff @(posedge CLK) begin
        if (push && !RST) mem_q[wr_ptr_q] <= SYS_IN_DATA;
    end

endmodule

// File: doc/sys_in_port.md
SYS_IN_PORT -- requirements
Module: sys_in_port

Interface
REQ-001 The block SHALL have a parameter DEPTH, default 4, giving the number of FIFO entries (power of two, at least 2).
REQ-002 The block SHALL have a parameter WIDTH, default 16, giving the data width and matching the CPU bus.
REQ-003 CLK  input  1  single system clock; all state changes on its rising edge.
REQ-004 RST  input  1  reset; synchronous, active-high.
REQ-005 SLOW_CLOCK_STRB  input  1  CPU-side step strobe; CPU-side pops occur only on edges where it is high.
REQ-006 SYS_IN_DATA  input  WIDTH  external producer data.
REQ-007 SYS_IN_VALID  input  1  external producer has a word on SYS_IN_DATA.
REQ-008 SYS_IN_READY  output  1  block can accept a word (not full).
REQ-009 IN_OUT  input  1  CPU control: drive the head word onto the bus and pop it.
REQ-010 DATA_OUT  output  WIDTH  word for the CPU bus mux.
REQ-011 EMPTY  output  1  FIFO holds zero words.
REQ-012 FULL  output  1  FIFO holds DEPTH words.
REQ-013 COUNT  output  log2(DEPTH)+1  current occupancy.
REQ-014 UNDERFLOW  output  1  sticky flag: a pop was attempted while the FIFO was empty.

Function
REQ-015 Push: on a CLK edge with SYS_IN_VALID=1 and SYS_IN_READY=1, the block SHALL write SYS_IN_DATA at the write pointer, independent of SLOW_CLOCK_STRB.
REQ-016 SYS_IN_READY SHALL equal NOT FULL (combinational from registered count); the producer holds VALID and DATA until accepted, so no data is dropped.
REQ-017 Pop: on a CLK edge with SLOW_CLOCK_STRB=1, IN_OUT=1 and EMPTY=0, the block SHALL advance the read pointer by one.
REQ-018 DATA_OUT SHALL be combinational: head word when IN_OUT=1 and EMPTY=0, else all zeros, so the bus is valid before the consuming register latches on the same strobe edge.
REQ-019 Pop latency SHALL be zero cycles (head visible while IN_OUT=1); push-to-visible latency SHALL be one CLK (word readable on the edge after acceptance).
REQ-020 Pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
REQ-021 Simultaneous push and pop on the same edge SHALL leave COUNT unchanged, with both pointers advancing.
REQ-022 Simultaneous push and pop while full: READY is 0, so only the pop occurs; COUNT decreases by 1 and READY rises the next cycle.
REQ-023 Simultaneous push and pop while empty: only the push occurs; DATA_OUT stays zero on that edge (no bypass), and UNDERFLOW is set.
REQ-024 Pop attempt while EMPTY=1 SHALL leave the pointers unchanged, drive DATA_OUT=0, and set UNDERFLOW, which holds until reset.
REQ-025 IN_OUT=1 with SLOW_CLOCK_STRB=0 SHALL drive DATA_OUT but SHALL NOT pop or set UNDERFLOW.
REQ-026 EMPTY SHALL be (COUNT==0) and FULL SHALL be (COUNT==DEPTH), both derived from a registered COUNT.
REQ-027 Storage contents SHALL NOT be observable except through DATA_OUT.

Reset
REQ-028 While RST=1 at a CLK edge, the block SHALL clear pointers and COUNT to 0 and clear UNDERFLOW, giving EMPTY=1, FULL=0, SYS_IN_READY=1 and DATA_OUT=0.
REQ-029 Reset SHALL override any push or pop on the same edge; in-flight data is discarded.
REQ-030 Storage array contents need not be cleared by reset.

Verification
REQ-031 Reset, then push 0x1234, then strobe with IN_OUT=1 -> DATA_OUT=0x1234 during the pop cycle; EMPTY=1 afterward; UNDERFLOW=0.
REQ-032 Push 0xA001..0xA004 back-to-back -> FULL=1, COUNT=4, READY=0; hold VALID with 0xA005 -> not accepted; pop once -> DATA_OUT=0xA001, then READY=1 and 0xA005 accepted.
REQ-033 Push 6 and pop 6 words interleaved across pointer wrap -> output order 0xB000..0xB005 exactly.
REQ-034 COUNT=2 with push and strobe-pop on the same edge -> COUNT stays 2; head advances to the next word.
REQ-035 Empty FIFO, strobe with IN_OUT=1 -> DATA_OUT=0, pointers unchanged, UNDERFLOW=1 and held; RST -> UNDERFLOW=0.
REQ-036 COUNT=3, assert RST together with push and pop -> COUNT=0, EMPTY=1, READY=1 on the next cycle.
